// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// States IDLE/START/DATA/[PARITY]/STOP; define UART_TX_PARITY_EN to include the PARITY state.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_INIT = 1'(PARITY_ODD);
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 1 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_tx: illegal parameter value");
    end

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic           stop_idx;
    logic [7:0]     shreg;
    logic           bit_end;
    logic           final_stop;
    logic           accept;

    assign bit_end    = (cnt == CNT_LAST);
    assign final_stop = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    // Opening ready in the last stop cycle lets the next start bit follow with no gap.
    assign ready      = (state == IDLE) || final_stop;
    assign done       = final_stop;
    assign accept     = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else if (accept) begin
            state    <= START;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= data_in;
            tx       <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        cnt   <= '0;
                        tx    <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= (^shreg) ^ PAR_INIT;
`else
                            state    <= STOP;
                            stop_idx <= 1'b0;
                            tx       <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        cnt      <= '0;
                        stop_idx <= 1'b0;
                        tx       <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; three instances cover 1 and 4 clocks per bit,
// 1 and 2 stop bits, and even/odd parity when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL_A = 10 + P;
    localparam int FL_B = (11 + P) * 4;
    localparam int FL_C = 10 + P;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst    = 1'b0;
    logic [2:0] valid_v = '0;
    logic [7:0] data_v [3];
    logic [2:0] ready_v, tx_v, busy_v, done_v;

    logic [63:0] cap_tx, cap_done, cap_ready, cap_busy;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 if (clk_en) clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst), .data_in(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .data_in(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .rst(rst), .data_in(data_v[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // tx per cycle after the accept edge, bit 0 = first cycle; idle (1) beyond the frame.
    function automatic logic [63:0] frame_model(input logic [7:0] d, input int cpb,
                                                input int stops, input int odd);
        logic [63:0] v;
        int          pos;
        logic        b;
        v   = '1;
        pos = 0;
        for (int k = 0; k < 9 + P + stops; k++) begin
            if (k == 0)                 b = 1'b0;
            else if (k <= 8)            b = d[k-1];
            else if (P == 1 && k == 9)  b = (^d) ^ odd[0];
            else                        b = 1'b1;
            for (int j = 0; j < cpb; j++) begin
                v[pos] = b;
                pos++;
            end
        end
        return v;
    endfunction

    task automatic capture(input int idx, input logic [7:0] d0, input logic [7:0] d1,
                           input bit hold, input int fl, input int n);
        @(negedge clk);
        chk($sformatf("ready_pre_%0d", idx), 64'(ready_v[idx]), 64'd1);
        valid_v[idx] = 1'b1;
        data_v[idx]  = d0;
        cap_tx = '1; cap_done = '0; cap_ready = '0; cap_busy = '0;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_tx[c-1]    = tx_v[idx];
            cap_done[c-1]  = done_v[idx];
            cap_ready[c-1] = ready_v[idx];
            cap_busy[c-1]  = busy_v[idx];
            if (c == 1) begin
                if (hold) begin
                    data_v[idx] = d1;
                end else begin
                    valid_v[idx] = 1'b0;
                    data_v[idx]  = ~d0;
                end
            end
            if (hold && c == fl + 1) valid_v[idx] = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] exp_tx;
        logic [7:0]  rx;
        logic        seen_done, all_high;

        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

        // reset with the clock stopped
        #1 rst = 1'b1;
        #1;
        chk("rst_tx",    64'(tx_v),    64'b111);
        chk("rst_ready", 64'(ready_v), 64'b111);
        chk("rst_busy",  64'(busy_v),  64'b000);
        chk("rst_done",  64'(done_v),  64'b000);
        #3 rst = 1'b0;
        clk_en = 1'b1;

        // single frame 0xA5
        capture(0, 8'hA5, 8'h00, 1'b0, FL_A, FL_A + 1);
`ifdef UART_TX_PARITY_EN
        exp_tx = frame_model(8'hA5, 1, 1, 0);
`else
        exp_tx = 64'hFFFF_FFFF_FFFF_FF4A;
`endif
        chk("a5_tx",    cap_tx,    exp_tx);
        chk("a5_done",  cap_done,  64'd1 << (FL_A - 1));
        chk("a5_ready", cap_ready, (64'd1 << (FL_A - 1)) | (64'd1 << FL_A));
        chk("a5_busy",  cap_busy,  (64'd1 << FL_A) - 64'd1);

        // bit stretching, 4 clocks per bit, 2 stop bits
        capture(1, 8'h00, 8'h00, 1'b0, FL_B, FL_B + 1);
`ifdef UART_TX_PARITY_EN
        exp_tx = frame_model(8'h00, 4, 2, 0);
`else
        exp_tx = 64'hFFFF_FFF0_0000_0000;
`endif
        chk("str_tx",   cap_tx,   exp_tx);
        chk("str_done", cap_done, 64'd1 << (FL_B - 1));
        chk("str_busy", cap_busy, (64'd1 << FL_B) - 64'd1);

        // back-to-back 0x55 then 0xC3 with valid held
        capture(0, 8'h55, 8'hC3, 1'b1, FL_A, 2 * FL_A + 1);
        exp_tx = (frame_model(8'h55, 1, 1, 0) & ((64'd1 << FL_A) - 64'd1)) |
                 (frame_model(8'hC3, 1, 1, 0) << FL_A);
        chk("b2b_tx",    cap_tx,    exp_tx);
        chk("b2b_done",  cap_done,  (64'd1 << (FL_A - 1)) | (64'd1 << (2 * FL_A - 1)));
        chk("b2b_busy",  cap_busy,  (64'd1 << (2 * FL_A)) - 64'd1);
        chk("b2b_ready", cap_ready, (64'd1 << (FL_A - 1)) | (64'd3 << (2 * FL_A - 1)));

        // 0x07 on even-parity and odd-parity instances
        capture(0, 8'h07, 8'h00, 1'b0, FL_A, FL_A + 1);
        chk("p07_even_tx", cap_tx, frame_model(8'h07, 1, 1, 0));
`ifdef UART_TX_PARITY_EN
        chk("p07_even_bit", 64'(cap_tx[9]), 64'd1);
        chk("p07_even_len", cap_done, 64'd1 << 10);
`endif
        capture(2, 8'h07, 8'h00, 1'b0, FL_C, FL_C + 1);
        chk("p07_odd_tx", cap_tx, frame_model(8'h07, 1, 1, 1));
`ifdef UART_TX_PARITY_EN
        chk("p07_odd_bit", 64'(cap_tx[9]), 64'd0);
`else
        chk("p07_stop_bit", 64'(cap_tx[9]), 64'd1);
`endif

        // reset during D3 of 0xFF
        @(negedge clk);
        chk("ff_ready_pre", 64'(ready_v[0]), 64'd1);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'hFF;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            valid_v[0] = 1'b0;
        end
        chk("ff_busy_d3",  64'(busy_v[0]),  64'd1);
        chk("ff_ready_d3", 64'(ready_v[0]), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx",    64'(tx_v[0]),    64'd1);
        chk("mid_rst_ready", 64'(ready_v[0]), 64'd1);
        chk("mid_rst_busy",  64'(busy_v[0]),  64'd0);
        chk("mid_rst_done",  64'(done_v[0]),  64'd0);
        #1 rst = 1'b0;
        seen_done = 1'b0;
        all_high  = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            seen_done = seen_done | done_v[0];
            all_high  = all_high & tx_v[0];
        end
        chk("post_rst_no_done", 64'(seen_done), 64'd0);
        chk("post_rst_idle_tx", 64'(all_high),  64'd1);

        // reset while the start bit drives tx low
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v[0]  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        chk("start_low", 64'(tx_v[0]), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("start_rst_tx", 64'(tx_v[0]), 64'd1);
        #1 rst = 1'b0;

        // loopback decode of 0x3C at 4 clocks per bit, sampling mid-bit
        capture(1, 8'h3C, 8'h00, 1'b0, FL_B, FL_B + 1);
        for (int i = 0; i < 8; i++) rx[i] = cap_tx[4 * (1 + i) + 2];
        chk("loop_start", 64'(cap_tx[2]), 64'd0);
        chk("loop_data",  64'(rx),        64'h3C);
        chk("loop_stop",  64'(cap_tx[4 * (9 + P) + 2]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter that drives the serial line consumed by uart_rx; it is the upstream stage of the receive path.
- Accepts one byte per valid/ready handshake and serialises it LSB first: start bit (0), 8 data bits, optional parity, then 1 or 2 stop bits (1).
- Used for loopback testing against uart_rx and as the chip's TX path.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit; any integer >= 1. 1 matches uart_rx's one-bit-per-clock timing.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only meaningful with UART_TX_PARITY_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  8  byte to send; sampled only on the accept edge
- valid  input  1  data_in is valid
- ready  output  1  block can accept a byte this cycle
- tx  output  1  serial line, idle high; registered
- busy  output  1  frame in progress (START through final stop bit)
- done  output  1  one-cycle pulse marking frame completion

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: tx=1, ready=1, busy=0, done=0.
  - State returns to IDLE; bit counter, cycle counter and shift register clear.
  - Reset mid-frame aborts the frame, and tx returns to 1 with no clock edge required.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on a back-to-back accept.
- Accept: rising edge with valid=1 and ready=1.
  - data_in is latched into the shift register.
  - Next state is START and tx=0 from that edge on, so the start bit is visible in the cycle after the accept edge.
  - data_in changes after the accept edge do not affect the frame in flight.
- Bit timing: every bit, including start, parity and stop, holds tx for exactly CLKS_PER_BIT cycles. A cycle counter runs 0..CLKS_PER_BIT-1.
- DATA: 8 bits sent LSB first, with a 3-bit index running 0..7.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- ready:
  - Combinational: high in IDLE.
  - Also high in the final clock cycle of the final stop bit, so back-to-back frames have no idle gap.
  - Low otherwise.
- Back-to-back: an accept in that final stop cycle goes directly to START. The next start bit follows the stop bit with no extra cycle.
- done: high for exactly one cycle, the final clock cycle of the final stop bit, whether or not a new byte is accepted in that cycle.
- busy: high from the cycle after the accept edge until the final stop cycle inclusive. It stays high across back-to-back frames.
- valid while ready=0 is ignored. No byte is queued.
- Frame length: (1 + 8 + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity and 0 without.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows D7 and drives, for CLKS_PER_BIT cycles, the XOR of the 8 latched data bits when PARITY_ODD=0, or its complement when PARITY_ODD=1.
  - The frame is 11 bits with STOP_BITS=1.
- Undefined:
  - The PARITY state, its logic and its use of PARITY_ODD are absent.
  - The frame is 10 bits with STOP_BITS=1.

Test Plan:
- Reset check: assert rst with clk stopped -> tx=1, ready=1, busy=0, done=0 immediately.
- Single frame: CLKS_PER_BIT=1, STOP_BITS=1, no parity; send 0xA5 -> tx over the 10 cycles after the accept edge is 0,1,0,1,0,0,1,0,1,1. done pulses in the 10th cycle. ready is low in cycles 1-9.
- Bit stretching: CLKS_PER_BIT=4, STOP_BITS=2; send 0x00 -> tx low for 36 cycles, then high for 8. The frame is 44 cycles. done is high only in cycle 44.
- Back-to-back: valid held high with 0x55 then 0xC3 -> the second start bit immediately follows the first stop bit with no gap. Two done pulses 10 cycles apart. busy never drops between frames.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): send 0x07 -> parity bit is 1 and the frame is 11 bits. With PARITY_ODD=1, send 0x07 -> parity bit is 0.
- Mid-frame reset and loopback:
  - Pulse rst during D3 of 0xFF -> tx=1 at once, ready=1, no done pulse.
  - Then loop tx into uart_rx, send 0x3C -> uart_rx data=0x3C.
